// File: rtl/c432_irq_pkg.sv
// Shared constants, bank/state encodings and helpers for the c432 interrupt sequencer.
package c432_irq_pkg;

    localparam int NUM_CH = 9;

    typedef enum logic [1:0] {
        BANK_NONE = 2'd0,
        BANK_A    = 2'd1,
        BANK_B    = 2'd2,
        BANK_C    = 2'd3
    } bank_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    // One-hot channel mask; out-of-range indices yield an empty mask.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [3:0] ch);
        logic [NUM_CH-1:0] oh;
        oh = {NUM_CH{1'b0}};
        if (ch < 4'(NUM_CH)) begin
            oh[ch] = 1'b1;
        end else begin
            oh = {NUM_CH{1'b0}};
        end
        return oh;
    endfunction

endpackage

// File: rtl/c432_prio_pick.sv
// Fixed-priority picker: bank A > B > C, then lowest channel index inside the winning bank.
module c432_prio_pick
    import c432_irq_pkg::*;
(
    input  logic [NUM_CH-1:0] elig_a,
    input  logic [NUM_CH-1:0] elig_b,
    input  logic [NUM_CH-1:0] elig_c,
    output logic              any,
    output bank_t             bank,
    output logic [3:0]        chan
);

    logic [NUM_CH-1:0] vec_s;

    // Bank selection followed by lowest-set-bit search on the chosen vector
    always_comb begin
        vec_s = {NUM_CH{1'b0}};
        bank  = BANK_NONE;
        chan  = 4'd0;
        if (|elig_a) begin
            vec_s = elig_a;
            bank  = BANK_A;
        end else if (|elig_b) begin
            vec_s = elig_b;
            bank  = BANK_B;
        end else if (|elig_c) begin
            vec_s = elig_c;
            bank  = BANK_C;
        end else begin
            vec_s = {NUM_CH{1'b0}};
            bank  = BANK_NONE;
        end
        any = |vec_s;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (vec_s[i]) begin
                chan = 4'(i);
            end else begin
                chan = chan;
            end
        end
    end

endmodule

// File: rtl/c432_irq_sequencer.sv
// Three-bank interrupt sequencer: latches requests, grants one at a time, holds until ack.
// Optional grant timeout is enabled by defining IRQ_TIMEOUT_EN.
module c432_irq_sequencer
    import c432_irq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] e_in,
    input  logic [NUM_CH-1:0] a_in,
    input  logic [NUM_CH-1:0] b_in,
    input  logic [NUM_CH-1:0] c_in,
    output logic              pa_out,
    output logic              pb_out,
    output logic              pc_out,
    output logic              irq_valid,
    output logic [1:0]        irq_bank,
    output logic [3:0]        chan_out,
    input  logic              irq_ack
`ifdef IRQ_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    logic [NUM_CH-1:0] pend_a_r, pend_b_r, pend_c_r;
    logic [NUM_CH-1:0] e_r;
    logic [NUM_CH-1:0] elig_a_s, elig_b_s, elig_c_s;
    logic [NUM_CH-1:0] clr_a_s, clr_b_s, clr_c_s;
    logic              pa_r, pb_r, pc_r;
    logic              pick_any_s;
    bank_t             pick_bank_s;
    logic [3:0]        pick_chan_s;
    state_t            state_r, state_s;
    logic              valid_r, valid_s;
    bank_t             bank_r, bank_s;
    logic [3:0]        chan_r, chan_s;
    logic              done_s, tmo_s, tmo_hit_s;

    // Enable is registered so enabling a pending bit grants two cycles later, like a new request.
    assign elig_a_s = pend_a_r & e_r;
    assign elig_b_s = pend_b_r & e_r;
    assign elig_c_s = pend_c_r & e_r;

    c432_prio_pick u_pick (
        .elig_a (elig_a_s),
        .elig_b (elig_b_s),
        .elig_c (elig_c_s),
        .any    (pick_any_s),
        .bank   (pick_bank_s),
        .chan   (pick_chan_s)
    );

`ifdef IRQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             timeout_err_r;

    assign tmo_hit_s   = (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_err_r;

    // Grant age counter and timeout pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r     <= {CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            if (state_r == ST_SERVE && state_s == ST_SERVE) begin
                tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
            end else begin
                tmo_cnt_r <= {CNT_W{1'b0}};
            end
            timeout_err_r <= tmo_s;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and next-grant logic; ack outranks timeout
    always_comb begin
        state_s = state_r;
        valid_s = valid_r;
        bank_s  = bank_r;
        chan_s  = chan_r;
        done_s  = 1'b0;
        tmo_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_s = ST_SERVE;
                    valid_s = 1'b1;
                    bank_s  = pick_bank_s;
                    chan_s  = pick_chan_s;
                end else begin
                    valid_s = 1'b0;
                    bank_s  = BANK_NONE;
                    chan_s  = 4'd0;
                end
            end
            ST_SERVE: begin
                if (irq_ack) begin
                    done_s = 1'b1;
                end else if (tmo_hit_s) begin
                    done_s = 1'b1;
                    tmo_s  = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
                if (done_s) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    bank_s  = BANK_NONE;
                    chan_s  = 4'd0;
                end else begin
                    state_s = ST_SERVE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                bank_s  = BANK_NONE;
                chan_s  = 4'd0;
            end
        endcase
    end

    // Clear mask for the granted bit when the grant is released
    always_comb begin
        clr_a_s = {NUM_CH{1'b0}};
        clr_b_s = {NUM_CH{1'b0}};
        clr_c_s = {NUM_CH{1'b0}};
        if (done_s) begin
            case (bank_r)
                BANK_A:  clr_a_s = ch_onehot(chan_r);
                BANK_B:  clr_b_s = ch_onehot(chan_r);
                BANK_C:  clr_c_s = ch_onehot(chan_r);
                default: clr_a_s = {NUM_CH{1'b0}};
            endcase
        end else begin
            clr_a_s = {NUM_CH{1'b0}};
        end
    end

    // Pending bits (new requests win over clears), enable sample and pending flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_a_r <= {NUM_CH{1'b0}};
            pend_b_r <= {NUM_CH{1'b0}};
            pend_c_r <= {NUM_CH{1'b0}};
            e_r      <= {NUM_CH{1'b0}};
            pa_r     <= 1'b0;
            pb_r     <= 1'b0;
            pc_r     <= 1'b0;
        end else begin
            pend_a_r <= (pend_a_r & ~clr_a_s) | a_in;
            pend_b_r <= (pend_b_r & ~clr_b_s) | b_in;
            pend_c_r <= (pend_c_r & ~clr_c_s) | c_in;
            e_r      <= e_in;
            pa_r     <= |elig_a_s;
            pb_r     <= |elig_b_s;
            pc_r     <= |elig_c_s;
        end
    end

    // FSM state and registered grant outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            bank_r  <= BANK_NONE;
            chan_r  <= 4'd0;
        end else begin
            state_r <= state_s;
            valid_r <= valid_s;
            bank_r  <= bank_s;
            chan_r  <= chan_s;
        end
    end

    assign pa_out    = pa_r;
    assign pb_out    = pb_r;
    assign pc_out    = pc_r;
    assign irq_valid = valid_r;
    assign irq_bank  = bank_r;
    assign chan_out  = chan_r;

endmodule

// File: doc/c432_irq_sequencer.md
C432_IRQ_SEQUENCER -- requirements
Module: c432_irq_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: cycles irq_valid may stay unacknowledged before timeout (range 2..255).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port e_in  input  9  per-channel enable mask, shared by banks A/B/C.
REQ-005 SHALL have ports a_in, b_in, c_in  input  9 each  interrupt request lines for banks A, B, C; level, sampled each cycle.
REQ-006 SHALL have ports pa_out, pb_out, pc_out  output  1 each  registered flag: bank has any pending-and-enabled channel.
REQ-007 SHALL have port irq_valid  output  1  grant presented to the servicing agent.
REQ-008 SHALL have port irq_bank  output  2  granted bank: 1=A, 2=B, 3=C, 0=none.
REQ-009 SHALL have port chan_out  output  4  granted channel index 0..8.
REQ-010 SHALL have port irq_ack  input  1  servicing agent accepts the current grant.
REQ-011 SHALL have port timeout_err  output  1  one-cycle pulse on a timed-out grant (present only with IRQ_TIMEOUT_EN).

Function
REQ-012 SHALL hold pending registers pend_a/b/c[8:0]; any request bit high at a rising edge sets the corresponding pending bit.
REQ-013 SHALL define eligible = pend & e_in per bank; disabled pending bits stay pending and are not lost.
REQ-014 SHALL select with fixed priority bank A > B > C, then the lowest channel index within the bank.
REQ-015 SHALL implement a two-state FSM: IDLE and SERVE.
REQ-016 In IDLE with any eligible bit, the FSM SHALL register the selection into irq_bank/chan_out, raise irq_valid and enter SERVE at the same edge.
REQ-017 Latency SHALL be fixed: a request high in cycle k produces irq_valid high in cycle k+2 when the FSM is idle.
REQ-018 In SERVE, irq_valid, irq_bank and chan_out SHALL stay stable until acknowledgment, even if e_in drops or higher-priority requests arrive.
REQ-019 irq_ack high in SERVE SHALL clear the granted pending bit, drop irq_valid and return to IDLE at that edge; back-to-back grants therefore have at least one idle cycle between them.
REQ-020 If a new request for the granted channel arrives in the same cycle as its ack, setting SHALL win, so the bit remains pending.
REQ-021 irq_ack while in IDLE SHALL be ignored.
REQ-022 pa_out/pb_out/pc_out SHALL equal the registered OR-reduction of each bank's eligible vector, updated every cycle independently of the FSM.
REQ-023 irq_bank and chan_out SHALL read 0 whenever irq_valid is low.

Reset
REQ-024 rst_n low SHALL immediately clear all pending bits, pa/pb/pc_out, irq_valid, irq_bank, chan_out, timeout_err and the timeout counter, and force IDLE, including mid-SERVE.
REQ-025 After rst_n deasserts, the first request sampling SHALL occur at the next rising edge.

Configuration
REQ-026 With macro IRQ_TIMEOUT_EN defined, a counter SHALL run in SERVE; after TIMEOUT_CYCLES cycles without ack it SHALL clear the granted pending bit, drop irq_valid, pulse timeout_err for one cycle and return to IDLE.
REQ-027 Without IRQ_TIMEOUT_EN, the timeout_err port and counter SHALL be absent and SERVE SHALL wait indefinitely for irq_ack.
REQ-028 An ack arriving in the same cycle as timeout expiry SHALL take precedence: normal clear, no timeout_err.

Structure
REQ-029 Package c432_irq_pkg SHALL hold NUM_CH=9, the bank encodings (BANK_NONE/A/B/C), and the FSM state enum.
REQ-030 Combinational selection SHALL be a sub-module c432_prio_pick (inputs: three eligible vectors; outputs: any, bank, channel).
REQ-031 The timeout counter width SHALL be the clog2 of TIMEOUT_CYCLES+1.

Verification
REQ-032 Reset then e_in=9'h1FF, a_in=9'h002 for one cycle -> irq_valid high 2 cycles later, irq_bank=1, chan_out=1, pa_out=1.
REQ-033 a_in=9'h000, b_in=9'h001, c_in=9'h001 simultaneous, e_in=9'h1FF -> grants (2,0) then (3,0), one idle cycle between, each after ack.
REQ-034 e_in=9'h000, c_in=9'h010 -> no grant and pc_out=0; then e_in=9'h010 -> grant (3,4) at +2 cycles.
REQ-035 During a SERVE of (2,3), raise a_in=9'h001 -> outputs hold (2,3) until ack; the next grant is (1,0).
REQ-036 With IRQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold ack -> irq_valid drops after 16 cycles, timeout_err pulses once, and the bit is cleared; repeat with ack on cycle 16 -> no timeout_err.
REQ-037 Assert rst_n low mid-SERVE with pending bits set -> all outputs 0 asynchronously; no grant after release until new requests arrive.
